// File: rtl/fir_output_requantizer.sv
// ============================================================================
// Module      : fir_output_requantizer
// Description : Rescales, rounds, saturates and decimates FIR filter results
//               into a show-ahead FIFO drained over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_output_requantizer #(
    parameter int N_IN       = 32,
    parameter int N_OUT      = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          Enable,
    input  logic [N_IN-1:0]               in_data,
    input  logic                          clr_flags,
    output logic [N_OUT-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          sat_flag,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int                        c_phase_w    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int                        c_addr_w     = $clog2(FIFO_DEPTH);
    localparam logic [c_phase_w-1:0]      c_phase_last = c_phase_w'(DECIM - 1);
    localparam logic [c_addr_w:0]         c_full_level = (c_addr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_addr_w:0]         c_one_level  = (c_addr_w + 1)'(1);
    // Half an output LSB; collapses to zero when SHIFT is zero.
    localparam logic signed [N_IN:0]      c_round      = ((N_IN + 1)'(1) << SHIFT) >> 1;
    localparam logic [N_OUT-1:0]          c_max_out    = {1'b0, {(N_OUT - 1){1'b1}}};
    localparam logic [N_OUT-1:0]          c_min_out    = {1'b1, {(N_OUT - 1){1'b0}}};

    logic [c_phase_w-1:0]   r_phase;
    logic                   r_s1_valid;
    logic signed [N_IN:0]   r_s1;
    logic [N_OUT-1:0]       r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0]    r_wr_ptr;
    logic [c_addr_w-1:0]    r_rd_ptr;
    logic [c_addr_w:0]      r_level;
    logic                   r_out_valid;
    logic [N_OUT-1:0]       r_out_data;
    logic                   r_sat;
    logic                   r_ovr;

    logic                   w_keep;
    logic signed [N_IN:0]   w_sum;
    logic [N_IN-N_OUT+1:0]  w_hi_bits;
    logic                   w_clip_pos;
    logic                   w_clip_neg;
    logic [N_OUT-1:0]       w_sat_val;
    logic                   w_sat_evt;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_push;
    logic                   w_drop;
    logic [c_addr_w-1:0]    w_rd_inc;
    logic [c_addr_w:0]      w_level_next;
    logic [N_OUT-1:0]       w_data_next;

    assign w_keep = Enable & (r_phase == '0);

    // One extra bit of headroom keeps the rounding add from wrapping.
    assign w_sum = signed'({in_data[N_IN-1], in_data}) + c_round;

    // Result fits in N_OUT bits only when all bits above the sign agree.
    assign w_hi_bits  = r_s1[N_IN:N_OUT-1];
    assign w_clip_pos = ~r_s1[N_IN] & (|w_hi_bits);
    assign w_clip_neg = r_s1[N_IN] & ~(&w_hi_bits);
    assign w_sat_val  = w_clip_pos ? c_max_out :
                        w_clip_neg ? c_min_out : r_s1[N_OUT-1:0];
    assign w_sat_evt  = r_s1_valid & (w_clip_pos | w_clip_neg);

    assign w_pop    = r_out_valid & out_ready;
    assign w_full   = (r_level == c_full_level);
    assign w_push   = r_s1_valid & (~w_full | w_pop);
    assign w_drop   = r_s1_valid & w_full & ~w_pop;
    assign w_rd_inc = r_rd_ptr + c_addr_w'(1);

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + c_one_level;
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - c_one_level;
        end
    end

    // Show-ahead head register: next entry on a pop, the incoming sample when
    // the FIFO is (or becomes) empty, otherwise hold the last presented value.
    always_comb begin
        w_data_next = r_out_data;
        if (w_pop && (r_level > c_one_level)) begin
            w_data_next = r_mem[w_rd_inc];
        end else if (w_push && (!r_out_valid || (w_pop && r_level == c_one_level))) begin
            w_data_next = w_sat_val;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_phase    <= '0;
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else begin
            if (Enable) begin
                r_phase <= (r_phase == c_phase_last) ? '0 : r_phase + c_phase_w'(1);
            end
            r_s1_valid <= w_keep;
            if (w_keep) begin
                r_s1 <= w_sum >>> SHIFT;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_sat_val;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_inc;
            end
            r_level     <= w_level_next;
            r_out_valid <= (w_level_next != '0);
            r_out_data  <= w_data_next;
        end
    end

    // Sticky flags: a new event in the same cycle takes priority over clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sat <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            if (w_sat_evt) begin
                r_sat <= 1'b1;
            end else if (clr_flags) begin
                r_sat <= 1'b0;
            end
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (clr_flags) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign fifo_level = r_level;
    assign sat_flag   = r_sat;
    assign overrun    = r_ovr;

endmodule

`default_nettype wire
